// File: rtl/pll_cfg_arbiter.sv
// Round-robin arbiter sharing one PLL reconfiguration port among NUM_REQ requesters.
// Suppresses re-applying the current config, bounds each handshake with a timeout.
module pll_cfg_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter logic [31:0] DEFAULT_CFG = 32'h0010_0277,
    parameter logic [15:0] TIMEOUT     = 16'd4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [32*NUM_REQ-1:0]  req_cfg_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     err_o,
    output logic                   busy_o,
    output logic [31:0]            last_cfg_o,
    output logic [31:0]            pll_wdata_o,
    output logic                   pll_wdata_valid_o,
    input  logic                   pll_w_ready_i
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StRelease, StHold} state_e;

    state_e             state;
    logic [IW-1:0]      ptr;
    logic [15:0]        count;
    logic               ok;

    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      cand_idx;
    logic [IW-1:0]      nxt_ptr;
    logic [NUM_REQ-1:0] win_oh;
    logic [31:0]        win_cfg;
    int unsigned        cand;

    // Scan downwards from the farthest slot so the last hit is the one nearest the pointer.
    always_comb begin
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand     = (32'(ptr) + 32'(i)) % NUM_REQ;
            cand_idx = cand[IW-1:0];
            if (req_i[cand_idx]) begin
                win_idx = cand_idx;
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
        win_cfg         = req_cfg_i[32*win_idx +: 32];
        nxt_ptr         = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= StIdle;
            ptr               <= '0;
            count             <= '0;
            ok                <= 1'b0;
            gnt_o             <= '0;
            done_o            <= '0;
            err_o             <= '0;
            busy_o            <= 1'b0;
            last_cfg_o        <= DEFAULT_CFG;
            pll_wdata_o       <= DEFAULT_CFG;
            pll_wdata_valid_o <= 1'b0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            unique case (state)
                StIdle: begin
                    // Ready still high means the controller is finishing an aborted handshake.
                    if (|req_i && !pll_w_ready_i) begin
                        ptr    <= nxt_ptr;
                        gnt_o  <= win_oh;
                        busy_o <= 1'b1;
                        if (win_cfg == last_cfg_o) begin
                            done_o <= win_oh;
                            state  <= StHold;
                        end else begin
                            pll_wdata_o       <= win_cfg;
                            pll_wdata_valid_o <= 1'b1;
                            state             <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (count != 16'hffff) begin
                        count <= count + 16'd1;
                    end
                    if (pll_w_ready_i) begin
                        last_cfg_o        <= pll_wdata_o;
                        pll_wdata_valid_o <= 1'b0;
                        ok                <= 1'b1;
                        state             <= StRelease;
                    end else if (count == TIMEOUT - 16'd1) begin
                        pll_wdata_valid_o <= 1'b0;
                        ok                <= 1'b0;
                        state             <= StRelease;
                    end
                end
                StRelease: begin
                    if (!pll_w_ready_i) begin
                        count <= '0;
                        state <= StHold;
                        if (ok) begin
                            done_o <= gnt_o;
                        end else begin
                            err_o <= gnt_o;
                        end
                    end
                end
                StHold: begin
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_pll_cfg_arbiter.sv
// Bench for pll_cfg_arbiter: directed scenarios followed by randomized request/handshake
// traffic, checked against a transaction-level round-robin model.
module tb_pll_cfg_arbiter;
    localparam int          N   = 3;
    localparam logic [31:0] DEF = 32'h0010_0277;
    localparam int          TO  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [32*N-1:0]  req_cfg = '0;
    logic             ready = 1'b0;
    logic [N-1:0]     gnt_o, done_o, err_o;
    logic             busy_o, valid_o;
    logic [31:0]      last_cfg_o, wdata_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_ptr = 0;
    logic [31:0] m_last = DEF;

    always #5 clk = ~clk;

    pll_cfg_arbiter #(
        .NUM_REQ     (N),
        .DEFAULT_CFG (DEF),
        .TIMEOUT     (16'(TO))
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_i             (req),
        .req_cfg_i         (req_cfg),
        .gnt_o             (gnt_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .busy_o            (busy_o),
        .last_cfg_o        (last_cfg_o),
        .pll_wdata_o       (wdata_o),
        .pll_wdata_valid_o (valid_o),
        .pll_w_ready_i     (ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick_winner();
        for (int i = 0; i < N; i++) begin
            if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [31:0] c);
        req_cfg[32*k +: 32] = c;
        req[k] = 1'b1;
    endtask

    // Serve the next transaction. Called at a negedge with the arbiter idle; d is the number
    // of valid-high cycles before ready rises, h the extra cycles ready stays high afterwards.
    task automatic run_txn(input int d, input int h, input bit drop_early);
        int          w;
        int          cyc;
        int          vcnt;
        bit          ok;
        bit          stable;
        bit          early;
        logic [31:0] c;
        logic [N-1:0] oh;
        w = pick_winner();
        if (w < 0) return;
        c = req_cfg[32*w +: 32];
        oh = '0;
        oh[w] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gnt_o == '0 && cyc < 20);
        check_eq("grant_latency", 32'(cyc), 32'd1);
        check_eq("grant_owner", 32'(gnt_o), 32'(oh));
        check_eq("busy_during", 32'(busy_o), 32'd1);
        if (gnt_o == '0) begin
            req[w] = 1'b0;
            return;
        end
        m_ptr = (w + 1) % N;
        if (c == m_last) begin
            check_eq("skip_done", 32'(done_o), 32'(oh));
            check_eq("skip_valid", 32'(valid_o), 32'd0);
        end else begin
            check_eq("issue_valid", 32'(valid_o), 32'd1);
            check_eq("issue_wdata", wdata_o, c);
            ok = (d <= TO - 1);
            vcnt = 0;
            stable = 1'b1;
            early = 1'b0;
            while (valid_o === 1'b1 && vcnt < 40) begin
                if (wdata_o !== c) stable = 1'b0;
                if ((done_o | err_o) != '0) early = 1'b1;
                if (vcnt == d) ready = 1'b1;
                if (drop_early && vcnt == 0) req[w] = 1'b0;
                vcnt++;
                @(negedge clk);
            end
            check_eq("valid_cycles", 32'(vcnt), ok ? 32'(d + 1) : 32'(TO));
            if (ok) begin
                repeat (h) begin
                    if ((done_o | err_o) != '0 || wdata_o !== c) early = 1'b1;
                    @(negedge clk);
                end
            end
            if ((done_o | err_o) != '0) early = 1'b1;
            ready = 1'b0;
            @(negedge clk);
            check_eq("wdata_stable", 32'(stable), 32'd1);
            check_eq("no_early_pulse", 32'(early), 32'd0);
            check_eq("done_pulse", 32'(done_o), ok ? 32'(oh) : 32'd0);
            check_eq("err_pulse", 32'(err_o), ok ? 32'd0 : 32'(oh));
            if (ok) m_last = c;
        end
        check_eq("last_cfg", last_cfg_o, m_last);
        req[w] = 1'b0;
        @(negedge clk);
        check_eq("idle_gnt", 32'(gnt_o), 32'd0);
        check_eq("idle_pulses", 32'(done_o | err_o), 32'd0);
        check_eq("idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] c;
        repeat (3) @(negedge clk);
        check_eq("rst_gnt", 32'(gnt_o), 32'd0);
        check_eq("rst_pulses", 32'(done_o | err_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_wdata", wdata_o, DEF);
        check_eq("rst_last", last_cfg_o, DEF);
        rst = 1'b0;
        @(negedge clk);

        set_req(0, DEF);
        run_txn(0, 0, 1'b0);
        set_req(1, 32'h0020_0311);
        run_txn(5, 0, 1'b0);
        set_req(0, 32'h0030_0101);
        set_req(1, 32'h0030_0202);
        set_req(2, 32'h0030_0303);
        repeat (3) run_txn(2, 1, 1'b0);
        set_req(0, 32'h0030_0404);
        run_txn(1, 0, 1'b0);
        set_req(1, 32'h0050_0666);
        run_txn(99, 0, 1'b0);
        set_req(2, 32'h0060_0777);
        run_txn(TO - 1, 3, 1'b0);
        set_req(0, 32'h0070_0888);
        run_txn(3, 0, 1'b1);

        // Reset in the middle of ISSUE while the controller keeps ready high.
        set_req(2, 32'h0044_0555);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (valid_o !== 1'b1 && cyc < 20);
        check_eq("pre_rst_valid", 32'(valid_o), 32'd1);
        rst = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        m_last = DEF;
        check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
        check_eq("mid_rst_last", last_cfg_o, DEF);
        check_eq("mid_rst_gnt", 32'(gnt_o), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check_eq("ready_guard_gnt", 32'(gnt_o), 32'd0);
        end
        ready = 1'b0;
        run_txn(1, 0, 1'b0);

        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0: c = m_last;
                        1: c = DEF;
                        default: c = {16'h00a0, 12'h000, 4'($urandom_range(0, 3))};
                    endcase
                    set_req(k, c);
                end
            end
            if (req == '0) set_req($urandom_range(0, N - 1), $urandom);
            run_txn($urandom_range(0, 19), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
